// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared constants and types for the instruction-fetch stage:
//               datapath width, reset PC, bubble encoding, register-index
//               field positions and the per-cycle fetch action encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  // addi x0,x0,0 - the canonical bubble
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Source register index fields of a 32-bit instruction word
  localparam int RS1_MSB = 19;
  localparam int RS1_LSB = 15;
  localparam int RS2_MSB = 24;
  localparam int RS2_LSB = 20;

  // Per-cycle action of the fetch stage
  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'b00,
    ACT_STALL    = 2'b01,
    ACT_REDIRECT = 2'b10
  } if_action_e;

  // Redirect targets are forced to word alignment
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] target);
    return {target[XLEN-1:2], 2'b00};
  endfunction

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Combinational hazard resolution for the fetch stage. Detects
//               load-use dependencies between the load in EX and the
//               instruction in ID, and picks the fetch action with redirect
//               taking priority over stall. Also produces the ID/EX flush.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
  import if_stage_pkg::*;
(
  input  logic            ex_redirect,
  input  logic            ex_memread,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ID_instr,
  input  logic            ID_valid,
  output logic            load_use,
  output logic            id_ex_flush,
  output if_action_e      action
);

  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_unused_instr;

  assign w_rs1 = ID_instr[RS1_MSB:RS1_LSB];
  assign w_rs2 = ID_instr[RS2_MSB:RS2_LSB];

  // Only the register-index fields matter for hazard detection
  assign w_unused_instr = ^{ID_instr[XLEN-1:RS2_MSB+1], ID_instr[RS1_LSB-1:0]};

  // Both source fields are compared regardless of format (conservative);
  // a redirect overrides a simultaneous stall.
  always_comb begin
    load_use    = 1'b0;
    id_ex_flush = 1'b0;
    action      = ACT_ADVANCE;

    load_use = ex_memread && (ex_rd != 5'd0) && ID_valid &&
               ((ex_rd == w_rs1) || (ex_rd == w_rs2));

    if (ex_redirect) begin
      action      = ACT_REDIRECT;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      action      = ACT_STALL;
      id_ex_flush = 1'b1;
    end
  end

endmodule : hazard_unit
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage and IF/ID pipeline register. Owns the
//               PC, drives the instruction-memory address, latches the
//               fetched instruction for decode and squashes wrong-path work
//               on EX-resolved redirects.
//               Optional feature macro: IF_PERF_CNT_EN adds saturating
//               stall/redirect cycle counters; without it both counter
//               outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
  import if_stage_pkg::*;
(
  input  logic            Clk,
  input  logic            Rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_memread,
  input  logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ID_PC,
  output logic [XLEN-1:0] ID_instr,
  output logic            ID_valid,
  output logic            id_ex_flush,
  output logic [XLEN-1:0] stall_cnt,
  output logic [XLEN-1:0] flush_cnt
);

  logic [XLEN-1:0] r_pc;
  logic            w_load_use;
  logic            w_unused_load_use;
  if_action_e      w_action;

  hazard_unit u_hazard (
    .ex_redirect (ex_redirect),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .ID_instr    (ID_instr),
    .ID_valid    (ID_valid),
    .load_use    (w_load_use),
    .id_ex_flush (id_ex_flush),
    .action      (w_action)
  );

  // Raw hazard flag is informational; the action select drives the datapath
  assign w_unused_load_use = w_load_use;

  assign imem_addr = r_pc;

  // Program counter: redirect to aligned target, hold on stall, else +4
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_pc <= RESET_PC;
    end else begin
      case (w_action)
        ACT_REDIRECT: r_pc <= align_target(ex_target);
        ACT_ADVANCE:  r_pc <= r_pc + 32'd4;
        default:      r_pc <= r_pc;
      endcase
    end
  end

  // IF/ID register: bubble on redirect, hold on stall, capture fetch otherwise
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ID_PC    <= '0;
      ID_instr <= NOP_INSTR;
      ID_valid <= 1'b0;
    end else begin
      case (w_action)
        ACT_REDIRECT: begin
          ID_PC    <= '0;
          ID_instr <= NOP_INSTR;
          ID_valid <= 1'b0;
        end
        ACT_ADVANCE: begin
          ID_PC    <= r_pc;
          ID_instr <= imem_rdata;
          ID_valid <= 1'b1;
        end
        default: begin
          ID_PC    <= ID_PC;
          ID_instr <= ID_instr;
          ID_valid <= ID_valid;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [XLEN-1:0] r_stall_cnt;
  logic [XLEN-1:0] r_flush_cnt;

  // Saturating counters of stall and redirect cycles
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((w_action == ACT_STALL) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if ((w_action == ACT_REDIRECT) && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage: directed vector table,
//               hand-written reset sequences and randomized cycles checked
//               against a behavioural model of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic [31:0] ID_PC;
  logic [31:0] ID_instr;
  logic        ID_valid;
  logic        id_ex_flush;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_instr;
  logic        m_id_valid;
  int unsigned m_scnt;
  int unsigned m_fcnt;

  typedef struct {
    logic        redir;
    logic [31:0] tgt;
    logic        mrd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        exp_flush;
    logic [31:0] exp_addr;
    logic [31:0] exp_id_pc;
    logic [31:0] exp_instr;
    logic        exp_valid;
    int unsigned exp_s;
    int unsigned exp_f;
  } vec_t;

  vec_t tbl[11];

  if_stage dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .ID_PC       (ID_PC),
    .ID_instr    (ID_instr),
    .ID_valid    (ID_valid),
    .id_ex_flush (id_ex_flush),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 Clk = ~Clk;

  // Counters read as zero when the feature is compiled out
  function automatic logic [31:0] cnt_exp(input int unsigned n);
`ifdef IF_PERF_CNT_EN
    return n;
`else
    return (n == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] t, input logic m,
                       input logic [4:0] d, input logic [31:0] w);
    ex_redirect = r;
    ex_target   = t;
    ex_memread  = m;
    ex_rd       = d;
    imem_rdata  = w;
  endtask

  task automatic model_reset();
    m_pc       = 32'h0;
    m_id_pc    = 32'h0;
    m_id_instr = NOP;
    m_id_valid = 1'b0;
    m_scnt     = 0;
    m_fcnt     = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_addr"},   imem_addr, m_pc);
    chk({tag, "_id_pc"},  ID_PC, m_id_pc);
    chk({tag, "_instr"},  ID_instr, m_id_instr);
    chk({tag, "_valid"},  {31'd0, ID_valid}, {31'd0, m_id_valid});
    chk({tag, "_scnt"},   stall_cnt, cnt_exp(m_scnt));
    chk({tag, "_fcnt"},   flush_cnt, cnt_exp(m_fcnt));
  endtask

  // One model-checked cycle; called with time just after a negedge
  task automatic model_cycle(input logic r, input logic [31:0] t, input logic m,
                             input logic [4:0] d, input logic [31:0] w);
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       hazard;
    drive(r, t, m, d, w);
    #1;
    rs1    = m_id_instr[19:15];
    rs2    = m_id_instr[24:20];
    hazard = m && (d != 5'd0) && m_id_valid && ((d == rs1) || (d == rs2));
    chk("rnd_flush", {31'd0, id_ex_flush}, {31'd0, (r || hazard)});
    chk("rnd_addr_pre", imem_addr, m_pc);
    @(posedge Clk);
    #1;
    if (r) begin
      m_pc       = {t[31:2], 2'b00};
      m_id_pc    = 32'h0;
      m_id_instr = NOP;
      m_id_valid = 1'b0;
      m_fcnt++;
    end else if (hazard) begin
      m_scnt++;
    end else begin
      m_id_pc    = m_pc;
      m_id_instr = w;
      m_id_valid = 1'b1;
      m_pc       = m_pc + 32'd4;
    end
    chk_state("rnd");
    @(negedge Clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        r;
    logic [31:0] t;
    logic        m;
    logic [4:0]  d;
    logic [31:0] w;

    tbl[0]  = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0050_0093, 1'b0, 32'h0000_0004, 32'h0,         32'h0050_0093, 1'b1, 0, 0};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 5'd0, 32'h0020_81B3, 1'b0, 32'h0000_0008, 32'h4,         32'h0020_81B3, 1'b1, 0, 0};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 5'd1, 32'h0000_0013, 1'b1, 32'h0000_0008, 32'h4,         32'h0020_81B3, 1'b1, 1, 0};
    tbl[3]  = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0020_81B3, 1'b0, 32'h0000_000C, 32'h8,         32'h0020_81B3, 1'b1, 1, 0};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 5'd5, 32'h2222_2222, 1'b0, 32'h0000_0010, 32'hC,         32'h2222_2222, 1'b1, 1, 0};
    tbl[5]  = '{1'b1, 32'h103,      1'b0, 5'd0, 32'h3333_3333, 1'b1, 32'h0000_0100, 32'h0,         NOP,           1'b0, 1, 1};
    tbl[6]  = '{1'b0, 32'h0,        1'b1, 5'd1, 32'h0020_81B3, 1'b0, 32'h0000_0104, 32'h100,       32'h0020_81B3, 1'b1, 1, 1};
    tbl[7]  = '{1'b1, 32'h200,      1'b1, 5'd2, 32'h5555_5555, 1'b1, 32'h0000_0200, 32'h0,         NOP,           1'b0, 1, 2};
    tbl[8]  = '{1'b1, 32'hFFFF_FFFF,1'b0, 5'd0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0,         NOP,           1'b0, 1, 3};
    tbl[9]  = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h4444_4444, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h4444_4444, 1'b1, 1, 3};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 5'd8, 32'h0,         1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 32'h4444_4444, 1'b1, 2, 3};

    // Reset state
    Rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0050_0093);
    #1;
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", ID_instr, NOP);
    chk("rst_valid", {31'd0, ID_valid}, 32'd0);
    chk("rst_flush", {31'd0, id_ex_flush}, 32'd0);
    chk("rst_id_pc", ID_PC, 32'h0);
    chk("rst_scnt",  stall_cnt, 32'h0);
    chk("rst_fcnt",  flush_cnt, 32'h0);
    @(negedge Clk);
    Rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].redir, tbl[i].tgt, tbl[i].mrd, tbl[i].rd, tbl[i].rdata);
      #1;
      chk($sformatf("vec%0d_flush", i), {31'd0, id_ex_flush}, {31'd0, tbl[i].exp_flush});
      @(posedge Clk);
      #1;
      chk($sformatf("vec%0d_addr", i),  imem_addr, tbl[i].exp_addr);
      chk($sformatf("vec%0d_id_pc", i), ID_PC, tbl[i].exp_id_pc);
      chk($sformatf("vec%0d_instr", i), ID_instr, tbl[i].exp_instr);
      chk($sformatf("vec%0d_valid", i), {31'd0, ID_valid}, {31'd0, tbl[i].exp_valid});
      chk($sformatf("vec%0d_scnt", i),  stall_cnt, cnt_exp(tbl[i].exp_s));
      chk($sformatf("vec%0d_fcnt", i),  flush_cnt, cnt_exp(tbl[i].exp_f));
      @(negedge Clk);
    end

    // Reset mid-run: advance twice, then assert Rst between edges
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0000_0013);
    @(negedge Clk);
    @(negedge Clk);
    chk("pre_midrst_addr", imem_addr, 32'h0000_0008);
    drive(1'b0, 32'h0, 1'b1, 5'd1, 32'h0);
    #2;
    Rst = 1'b1;
    #1;
    chk("midrst_addr",  imem_addr, 32'h0);
    chk("midrst_id_pc", ID_PC, 32'h0);
    chk("midrst_instr", ID_instr, NOP);
    chk("midrst_valid", {31'd0, ID_valid}, 32'd0);
    chk("midrst_flush", {31'd0, id_ex_flush}, 32'd0);
    chk("midrst_scnt",  stall_cnt, 32'h0);
    chk("midrst_fcnt",  flush_cnt, 32'h0);
    // A redirect while reset is held must not move the PC
    drive(1'b1, 32'h0000_0400, 1'b0, 5'd0, 32'h0);
    @(posedge Clk);
    #1;
    chk("rsthold_addr", imem_addr, 32'h0);
    chk("rsthold_fcnt", flush_cnt, 32'h0);
    @(negedge Clk);
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    Rst = 1'b0;
    model_reset();

    // Randomized cycles against the behavioural model
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 7) == 0);
      t = $urandom;
      m = ($urandom_range(0, 2) == 0);
      d = 5'($urandom_range(0, 3));
      w = $urandom;
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      model_cycle(r, t, m, d, w);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_if_stage
`default_nettype wire
